// File: rtl/fp_convert_pipe_if.sv
// Handshake bus for fp_convert_pipe.
//   in_valid/in_ready/in_data : two's-complement sample stream into the converter
//   out_valid/out_ready       : result stream out of the converter
//   out_sign/out_exp/out_sig  : sign, exponent and significand of the result
//   out_sat                   : result was clamped
// slave = converter side, master = producer/consumer side.
interface fp_convert_pipe_if #(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned EXP_W = 3,
  parameter int unsigned SIG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [SIG_W-1:0] out_sig;
  logic             out_sat;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_sig, out_sat
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_sig, out_sat
  );
endinterface

// File: rtl/fp_convert_pipe.sv
// Three-stage two's-complement to sign/exponent/significand converter.
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   bus        : slave side of fp_convert_pipe_if (valid/ready in and out)
// Stage 1 takes sign and magnitude, stage 2 normalises (exponent, significand,
// round bit), stage 3 rounds and drives the registered outputs. A stage loads
// whenever it is empty or the stage after it is loading, so in_ready ripples
// combinationally back from out_ready.
module fp_convert_pipe #(
  parameter int unsigned IN_W     = 12,
  parameter int unsigned EXP_W    = 3,
  parameter int unsigned SIG_W    = 4,
  parameter bit          ROUND_EN = 1'b1
) (
  input logic clk,
  input logic rst_n,
  fp_convert_pipe_if.slave bus
);

  localparam logic [IN_W-1:0]  MOST_NEG = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0]  MAX_MAG  = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [EXP_W-1:0] EMAX     = EXP_W'(IN_W - SIG_W - 1);
  localparam logic [SIG_W-1:0] F_MSB    = {1'b1, {(SIG_W-1){1'b0}}};

  logic             v1, sign1, sat1;
  logic [IN_W-1:0]  mag1;
  logic             v2, sign2, sat2, r2;
  logic [EXP_W-1:0] e2;
  logic [SIG_W-1:0] f2;
  logic             v3, sign3, sat3;
  logic [EXP_W-1:0] e3;
  logic [SIG_W-1:0] f3;

  logic             ld1_c, ld2_c, ld3_c;
  logic [IN_W-1:0]  neg_c;
  logic [EXP_W-1:0] e_c;
  logic [SIG_W-1:0] f_c;
  logic             r_c;
  logic [SIG_W:0]   sum_c;
  logic [EXP_W-1:0] e_rnd_c;
  logic [SIG_W-1:0] f_rnd_c;
  logic             sat_rnd_c;

  // Ripple stall chain from the output back to the input.
  assign ld3_c        = !v3 || bus.out_ready;
  assign ld2_c        = !v2 || ld3_c;
  assign ld1_c        = !v1 || ld2_c;
  assign bus.in_ready = ld1_c;

  assign neg_c = '0 - bus.in_data;

  // Normalise: exponent is the shift that puts the leading one in the top significand bit.
  always_comb begin
    e_c = '0;
    for (int unsigned i = SIG_W; i < IN_W; i++) begin
      if (mag1[i]) e_c = EXP_W'(i - SIG_W + 1);
    end
    f_c = SIG_W'(mag1 >> e_c);
    r_c = 1'({mag1, 1'b0} >> e_c);
  end

  // Round half-up; a carry out renormalises, or clamps at the top exponent.
  always_comb begin
    e_rnd_c   = e2;
    f_rnd_c   = f2;
    sat_rnd_c = 1'b0;
    sum_c     = {1'b0, f2} + (SIG_W+1)'(1);
    if (ROUND_EN && r2) begin
      if (sum_c[SIG_W]) begin
        if (e2 == EMAX) begin
          f_rnd_c   = '1;
          sat_rnd_c = 1'b1;
        end else begin
          f_rnd_c = F_MSB;
          e_rnd_c = e2 + EXP_W'(1);
        end
      end else begin
        f_rnd_c = sum_c[SIG_W-1:0];
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0; sign1 <= 1'b0; sat1 <= 1'b0; mag1 <= '0;
      v2 <= 1'b0; sign2 <= 1'b0; sat2 <= 1'b0; r2 <= 1'b0; e2 <= '0; f2 <= '0;
      v3 <= 1'b0; sign3 <= 1'b0; sat3 <= 1'b0; e3 <= '0; f3 <= '0;
    end else begin
      if (ld1_c) begin
        v1 <= bus.in_valid;
        if (bus.in_valid) begin
          sign1 <= bus.in_data[IN_W-1];
          // The most negative input has no positive twin; clamp and flag it.
          if (bus.in_data == MOST_NEG) begin
            mag1 <= MAX_MAG;
            sat1 <= 1'b1;
          end else begin
            mag1 <= bus.in_data[IN_W-1] ? neg_c : bus.in_data;
            sat1 <= 1'b0;
          end
        end
      end
      if (ld2_c) begin
        v2 <= v1;
        if (v1) begin
          sign2 <= sign1;
          sat2  <= sat1;
          e2    <= e_c;
          f2    <= f_c;
          r2    <= r_c;
        end
      end
      if (ld3_c) begin
        v3 <= v2;
        if (v2) begin
          sign3 <= sign2;
          e3    <= e_rnd_c;
          f3    <= f_rnd_c;
          sat3  <= sat2 || sat_rnd_c;
        end
      end
    end
  end

  assign bus.out_valid = v3;
  assign bus.out_sign  = sign3;
  assign bus.out_exp   = e3;
  assign bus.out_sig   = f3;
  assign bus.out_sat   = sat3;

endmodule

// File: tb/tb_fp_convert_pipe.sv
// Scoreboard bench for fp_convert_pipe: one rounding and one truncating
// instance share a stimulus stream; each has its own expectation queue and monitor.
module tb_fp_convert_pipe;
  localparam int unsigned IN_W  = 12;
  localparam int unsigned EXP_W = 3;
  localparam int unsigned SIG_W = 4;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] e;
    logic [SIG_W-1:0] f;
    logic             sat;
  } res_t;

  typedef struct {
    int   data;
    res_t rnd;
    res_t trn;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_convert_pipe_if #(.IN_W(IN_W), .EXP_W(EXP_W), .SIG_W(SIG_W)) bus_r ();
  fp_convert_pipe_if #(.IN_W(IN_W), .EXP_W(EXP_W), .SIG_W(SIG_W)) bus_t ();

  fp_convert_pipe #(.IN_W(IN_W), .EXP_W(EXP_W), .SIG_W(SIG_W), .ROUND_EN(1'b1)) dut_r (
    .clk(clk), .rst_n(rst_n), .bus(bus_r)
  );
  fp_convert_pipe #(.IN_W(IN_W), .EXP_W(EXP_W), .SIG_W(SIG_W), .ROUND_EN(1'b0)) dut_t (
    .clk(clk), .rst_n(rst_n), .bus(bus_t)
  );

  int   tests = 0;
  int   fails = 0;
  res_t q_r[$];
  res_t q_t[$];
  vec_t vecs[16];
  logic rand_rdy = 1'b0;
  logic stall_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic res_t mk(input logic s, input int e, input int f, input logic sat);
    res_t r;
    r.sign = s;
    r.e    = EXP_W'(e);
    r.f    = SIG_W'(f);
    r.sat  = sat;
    return r;
  endfunction

  task automatic set_ready(input logic v);
    bus_r.out_ready = v;
    bus_t.out_ready = v;
  endtask

  task automatic drive_in(input logic v, input int d);
    bus_r.in_valid = v;
    bus_t.in_valid = v;
    bus_r.in_data  = IN_W'(d);
    bus_t.in_data  = IN_W'(d);
  endtask

  // Present vector idx until accepted, then queue both expectations.
  task automatic send(input int idx);
    logic acc;
    acc = 1'b0;
    drive_in(1'b1, vecs[idx].data);
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = bus_r.in_ready;
      if (!acc) stall_seen = 1'b1;
      @(posedge clk);
      #1;
    end
    if (acc) begin
      q_r.push_back(vecs[idx].rnd);
      q_t.push_back(vecs[idx].trn);
    end else begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready 0 for 200 cycles expected acceptance of %0d", vecs[idx].data);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 1000 && (q_r.size() != 0 || q_t.size() != 0); k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_r", 32'(q_r.size()), 32'd0);
    chk("drain_t", 32'(q_t.size()), 32'd0);
  endtask

  task automatic mon_step(input int sel, input logic v, input logic rdy, input res_t cur,
                          inout logic hold, inout res_t held);
    res_t exp;
    if (hold) begin
      chk(sel == 0 ? "hold_valid_r" : "hold_valid_t", 32'(v), 32'd1);
      chk(sel == 0 ? "hold_data_r" : "hold_data_t", 32'(cur), 32'(held));
    end
    if (v && rdy) begin
      if ((sel == 0 ? q_r.size() : q_t.size()) == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_%s: got result 0x%0h expected none", sel == 0 ? "r" : "t", cur);
      end else begin
        exp = (sel == 0) ? q_r.pop_front() : q_t.pop_front();
        chk(sel == 0 ? "result_r" : "result_t", 32'(cur), 32'(exp));
      end
    end
    hold = v && !rdy;
    held = cur;
  endtask

  // Output monitors.
  initial begin
    logic hold_r, hold_t;
    res_t held_r, held_t;
    res_t cur_r, cur_t;
    hold_r = 1'b0; hold_t = 1'b0;
    held_r = '0;   held_t = '0;
    forever begin
      @(negedge clk);
      cur_r = {bus_r.out_sign, bus_r.out_exp, bus_r.out_sig, bus_r.out_sat};
      cur_t = {bus_t.out_sign, bus_t.out_exp, bus_t.out_sig, bus_t.out_sat};
      if (!rst_n) begin
        hold_r = 1'b0;
        hold_t = 1'b0;
      end else begin
        mon_step(0, bus_r.out_valid, bus_r.out_ready, cur_r, hold_r, held_r);
        mon_step(1, bus_t.out_valid, bus_t.out_ready, cur_t, hold_t, held_t);
      end
    end
  end

  // Random backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) set_ready(1'($urandom_range(0, 1)));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // data, expected with rounding, expected with truncation
    vecs[0]  = '{422,   mk(0, 5, 13, 0), mk(0, 5, 13, 0)};
    vecs[1]  = '{125,   mk(0, 4, 8, 0),  mk(0, 3, 15, 0)};
    vecs[2]  = '{2047,  mk(0, 7, 15, 1), mk(0, 7, 15, 0)};
    vecs[3]  = '{-2048, mk(1, 7, 15, 1), mk(1, 7, 15, 1)};
    vecs[4]  = '{-1,    mk(1, 0, 1, 0),  mk(1, 0, 1, 0)};
    vecs[5]  = '{0,     mk(0, 0, 0, 0),  mk(0, 0, 0, 0)};
    vecs[6]  = '{56,    mk(0, 2, 14, 0), mk(0, 2, 14, 0)};
    vecs[7]  = '{15,    mk(0, 0, 15, 0), mk(0, 0, 15, 0)};
    vecs[8]  = '{16,    mk(0, 1, 8, 0),  mk(0, 1, 8, 0)};
    vecs[9]  = '{31,    mk(0, 2, 8, 0),  mk(0, 1, 15, 0)};
    vecs[10] = '{-125,  mk(1, 4, 8, 0),  mk(1, 3, 15, 0)};
    vecs[11] = '{1000,  mk(0, 7, 8, 0),  mk(0, 6, 15, 0)};
    vecs[12] = '{1024,  mk(0, 7, 8, 0),  mk(0, 7, 8, 0)};
    vecs[13] = '{-1024, mk(1, 7, 8, 0),  mk(1, 7, 8, 0)};
    vecs[14] = '{8,     mk(0, 0, 8, 0),  mk(0, 0, 8, 0)};
    vecs[15] = '{-422,  mk(1, 5, 13, 0), mk(1, 5, 13, 0)};

    set_ready(1'b1);
    drive_in(1'b0, 0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // State right after reset release.
    @(negedge clk);
    chk("rst_out_valid_r", 32'(bus_r.out_valid), 32'd0);
    chk("rst_in_ready_r", 32'(bus_r.in_ready), 32'd1);
    chk("rst_fields_r", 32'({bus_r.out_sign, bus_r.out_exp, bus_r.out_sig, bus_r.out_sat}), 32'd0);
    chk("rst_out_valid_t", 32'(bus_t.out_valid), 32'd0);
    chk("rst_in_ready_t", 32'(bus_t.in_ready), 32'd1);
    chk("rst_fields_t", 32'({bus_t.out_sign, bus_t.out_exp, bus_t.out_sig, bus_t.out_sat}), 32'd0);
    @(posedge clk);
    #1;

    // Single sample latency: out_valid in the third cycle counting the transfer cycle.
    send(0);
    drive_in(1'b0, 0);
    @(negedge clk);
    chk("lat_cycle1", 32'(bus_r.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2", 32'(bus_r.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle3", 32'(bus_r.out_valid), 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Every directed vector back to back.
    for (int i = 0; i < 16; i++) send(i);
    drive_in(1'b0, 0);
    drain();

    // Backpressure: out_ready low for five cycles while four samples stream in.
    stall_seen = 1'b0;
    fork
      begin
        send(6);
        send(1);
        send(0);
        send(2);
        drive_in(1'b0, 0);
      end
      begin
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        set_ready(1'b0);
        repeat (5) @(posedge clk);
        #1;
        set_ready(1'b1);
      end
    join
    chk("bp_in_ready_drop", 32'(stall_seen), 32'd1);
    drain();

    // Random valid gaps and random out_ready over the vector table.
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        drive_in(1'b0, 0);
        @(posedge clk);
        #1;
      end
      send(int'($urandom_range(0, 15)));
    end
    drive_in(1'b0, 0);
    for (int k = 0; k < 1000 && (q_r.size() != 0 || q_t.size() != 0); k++) begin
      @(posedge clk);
      #1;
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    set_ready(1'b1);
    @(posedge clk);
    #1;
    drain();

    // Reset with three samples stuck in the pipe.
    set_ready(1'b0);
    send(6);
    send(1);
    send(4);
    drive_in(1'b0, 0);
    rst_n = 1'b0;
    q_r.delete();
    q_t.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid_r", 32'(bus_r.out_valid), 32'd0);
    chk("mid_rst_in_ready_r", 32'(bus_r.in_ready), 32'd1);
    chk("mid_rst_fields_r", 32'({bus_r.out_sign, bus_r.out_exp, bus_r.out_sig, bus_r.out_sat}), 32'd0);
    chk("mid_rst_out_valid_t", 32'(bus_t.out_valid), 32'd0);
    chk("mid_rst_in_ready_t", 32'(bus_t.in_ready), 32'd1);
    rst_n = 1'b1;
    set_ready(1'b1);
    repeat (10) @(posedge clk);
    #1;
    send(15);
    drive_in(1'b0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_convert_pipe.md
Name: fp_convert_pipe

Overview:
- Parametrised, pipelined two's-complement to sign/exponent/significand floating-point converter.
- Generalises the fixed 12-bit single-cycle converter path:
  - widths are configurable;
  - leading-zero detection, extraction and rounding are split into 3 registered stages;
  - valid/ready handshakes on input and output;
  - rounding mode is selectable;
  - a saturation flag is reported.
- Sits between sample sources (switch/ADC/accumulator results) and display or downstream arithmetic.

Parameters:
- IN_W, 12, input width (two's complement); IN_W >= SIG_W+2.
- EXP_W, 3, exponent width; 2^EXP_W - 1 must be >= IN_W-SIG_W-1.
- SIG_W, 4, significand width.
- ROUND_EN, 1, 1 = round half-up on the bit below the significand; 0 = truncate.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  in_data valid this cycle
- in_ready  output  1  stage 1 can accept
- in_data  input  IN_W  two's-complement sample
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_sign  output  1  sign bit
- out_exp  output  EXP_W  exponent
- out_sig  output  SIG_W  significand
- out_sat  output  1  result was clamped (most-negative input or rounding overflow at max exponent)

Behaviour:
- Reset:
  - Reset is sampled on clk while rst_n=0.
  - All stage valid bits clear; out_valid=0; out_sign/out_exp/out_sig/out_sat=0.
  - in_ready=1 during the cycle after reset release.
  - Reset mid-operation discards all in-flight samples; nothing is emitted for them.
- Handshake:
  - A transfer occurs on a cycle with valid&ready.
  - Stage k loads when its valid is 0 or stage k+1 loads / out_ready=1 (ripple stall).
  - in_ready = stage-1 can load; in_ready is combinational from out_ready through the stall chain.
  - While out_valid=1 and out_ready=0, all out_* stay stable and out_valid stays 1.
  - Latency is 3 cycles from input transfer to out_valid with out_ready held 1.
  - Throughput is 1 sample per cycle, with no bubbles under continuous valid/ready.
  - Order is preserved; no sample is dropped or duplicated under any in_valid/out_ready pattern.
- Stage 1 (sign/magnitude):
  - sign = in_data[IN_W-1].
  - mag = sign ? -in_data : in_data, computed on IN_W bits.
  - If in_data = 100..0 (most negative), mag = 011..1 and sat1 = 1.
  - mag[IN_W-1] is always 0 after this stage.
- Stage 2 (normalise):
  - lz = leading zeros of mag (IN_W bits); lz = IN_W when mag = 0.
  - E = max(0, IN_W-SIG_W-lz).
  - F = mag[E+SIG_W-1:E].
  - r = (E>0) ? mag[E-1] : 0.
- Stage 3 (round):
  - If ROUND_EN=1 and r=1, F = F+1.
  - On carry out of F: F = 100..0 and E = E+1.
  - If E was already EMAX = IN_W-SIG_W-1, saturate instead: E = EMAX, F = all ones, sat = 1.
  - out_sat = sat1 | rounding saturation.
- Zero input gives sign=0, E=0, F=0, sat=0.
- Negative values reproduce the magnitude result with sign=1. -0 cannot occur.

Test Plan:
- Reset then single sample, ROUND_EN=1: in_data=422 (0x1A6), out_ready=1 -> 3 cycles later out_valid=1, sign=0, exp=5, sig=13, sat=0.
- Rounding carry: in_data=125 -> exp=4, sig=8. Same input with ROUND_EN=0 -> exp=3, sig=15.
- Saturation cases:
  - in_data=2047 -> exp=7, sig=15, sat=1.
  - in_data=-2048 (0x800) -> sign=1, exp=7, sig=15, sat=1.
  - in_data=-1 -> sign=1, exp=0, sig=1, sat=0.
  - in_data=0 -> all zero.
- Backpressure: stream 56, 125, 422, 2047 back-to-back while out_ready is held 0 from cycle 2 to cycle 6:
  - in_ready drops once all 3 stages are full;
  - out_* hold (exp=2, sig=14) stable;
  - after release the 4 results emerge in order, none lost.
- Random 10k samples with random in_valid/out_ready, checked against a reference model -> every result matches and ordering is preserved.
- Reset asserted while 3 samples are in flight -> next cycle out_valid=0 and in_ready=1; no stale result appears after rst_n returns to 1.
